operand_fetch: RTL and testbench

// Initiator side of the copperv register file. Takes decoded source-register

---
 rtl/copperv_pkg.sv | 22 ++
 rtl/operand_fetch_if.sv | 55 +++++
 rtl/operand_bypass.sv | 26 ++
 rtl/operand_fetch.sv | 115 +++++++++++
 tb/tb_operand_fetch.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/copperv_pkg.sv
// Shared types for the copperv core: register address and data widths,
// plus the operand fetch sequencer states.
package copperv_pkg;

   localparam int REG_ADR_W = 5;
   localparam int DATA_W    = 32;

   typedef logic [REG_ADR_W-1:0] reg_adr_td;
   typedef logic [DATA_W-1:0]    data_td;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } opf_state_td;

   // x0 is hardwired to zero: never written, always reads as 0.
   function automatic logic is_x0(input reg_adr_td adr);
      return adr == '0;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of every signal operand_fetch exchanges with decode, writeback,
// the register file and execute. master is the operand_fetch view,
// slave is the view of the surrounding pipeline.
interface operand_fetch_if;
   import copperv_pkg::*;

   logic      dec_valid;
   logic      dec_ready;
   logic      dec_rs1_en;
   logic      dec_rs2_en;
   reg_adr_td dec_rs1;
   reg_adr_td dec_rs2;

   logic      wb_valid;
   reg_adr_td wb_rd;
   data_td    wb_data;

   logic      rf_rd_en;
   reg_adr_td rf_rd;
   data_td    rf_rd_din;
   logic      rf_rs1_en;
   logic      rf_rs2_en;
   reg_adr_td rf_rs1;
   reg_adr_td rf_rs2;
   data_td    rf_rs1_dout;
   data_td    rf_rs2_dout;

   logic      op_valid;
   logic      op_ready;
   data_td    op_rs1;
   data_td    op_rs2;

   modport master (
      input  dec_valid, dec_rs1_en, dec_rs2_en, dec_rs1, dec_rs2,
      output dec_ready,
      input  wb_valid, wb_rd, wb_data,
      output rf_rd_en, rf_rd, rf_rd_din,
      output rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2,
      input  rf_rs1_dout, rf_rs2_dout,
      output op_valid, op_rs1, op_rs2,
      input  op_ready
   );

   modport slave (
      output dec_valid, dec_rs1_en, dec_rs2_en, dec_rs1, dec_rs2,
      input  dec_ready,
      output wb_valid, wb_rd, wb_data,
      input  rf_rd_en, rf_rd, rf_rd_din,
      input  rf_rs1_en, rf_rs2_en, rf_rs1, rf_rs2,
      output rf_rs1_dout, rf_rs2_dout,
      input  op_valid, op_rs1, op_rs2,
      output op_ready
   );

endinterface

// File: rtl/operand_bypass.sv
// Selects the value captured for one operand during the read cycle:
// zero for unused or x0 operands, the writeback value when it targets
// the same register on this edge, otherwise the register file data.
module operand_bypass
   import copperv_pkg::*;
(
   input  logic      en,
   input  reg_adr_td adr,
   input  logic      wb_valid,
   input  reg_adr_td wb_rd,
   input  data_td    wb_data,
   input  data_td    rf_dout,
   output data_td    operand
);

   // Priority: unused/x0 beats bypass beats register file read data.
   always_comb begin
      operand = rf_dout;
      if (!en || is_x0(adr)) begin
         operand = '0;
      end else if (wb_valid && (wb_rd == adr)) begin
         operand = wb_data;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: owns all register file ports, issues reads for
// decoded requests and hands both operands to execute over valid/ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request in flight, ready for decode
// READ  | read issued last edge, register file data arrives this cycle
// HOLD  | operands captured and presented to execute (op_valid=1)
module operand_fetch
   import copperv_pkg::*;
(
   input logic             clk,
   input logic             rst,
   operand_fetch_if.master bus
);

   opf_state_td state;
   logic        op_valid_q;
   data_td      op_rs1_q;
   data_td      op_rs2_q;
   logic        rs1_en_q;
   logic        rs2_en_q;
   reg_adr_td   rs1_q;
   reg_adr_td   rs2_q;
   data_td      cap_rs1;
   data_td      cap_rs2;
   logic        accept;

   // Writeback goes straight through; x0 writes are suppressed.
   assign bus.rf_rd_en  = bus.wb_valid && !is_x0(bus.wb_rd);
   assign bus.rf_rd     = bus.wb_rd;
   assign bus.rf_rd_din = bus.wb_data;

   // The register file drops reads in a cycle it writes, so a request
   // is never accepted while a writeback is present.
   assign bus.dec_ready = !bus.wb_valid &&
                          ((state == IDLE) || ((state == HOLD) && bus.op_ready));
   assign accept        = bus.dec_valid && bus.dec_ready;

   // rs2 is only serviced together with rs1, so any request raises rs1_en.
   assign bus.rf_rs1_en = accept && (bus.dec_rs1_en || bus.dec_rs2_en);
   assign bus.rf_rs2_en = accept && bus.dec_rs2_en;
   assign bus.rf_rs1    = bus.dec_rs1;
   assign bus.rf_rs2    = bus.dec_rs2;

   assign bus.op_valid  = op_valid_q;
   assign bus.op_rs1    = op_rs1_q;
   assign bus.op_rs2    = op_rs2_q;

   operand_bypass u_bypass_rs1 (
      .en       (rs1_en_q),
      .adr      (rs1_q),
      .wb_valid (bus.wb_valid),
      .wb_rd    (bus.wb_rd),
      .wb_data  (bus.wb_data),
      .rf_dout  (bus.rf_rs1_dout),
      .operand  (cap_rs1)
   );

   operand_bypass u_bypass_rs2 (
      .en       (rs2_en_q),
      .adr      (rs2_q),
      .wb_valid (bus.wb_valid),
      .wb_rd    (bus.wb_rd),
      .wb_data  (bus.wb_data),
      .rf_dout  (bus.rf_rs2_dout),
      .operand  (cap_rs2)
   );

   // Sequencer with registered operand outputs; request fields are
   // latched on accept so capture does not depend on decode holding them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_valid_q <= 1'b0;
         op_rs1_q   <= '0;
         op_rs2_q   <= '0;
         rs1_en_q   <= 1'b0;
         rs2_en_q   <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
      end else begin
         if (accept) begin
            rs1_en_q <= bus.dec_rs1_en;
            rs2_en_q <= bus.dec_rs2_en;
            rs1_q    <= bus.dec_rs1;
            rs2_q    <= bus.dec_rs2;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= READ;
               end
            end
            READ: begin
               state      <= HOLD;
               op_valid_q <= 1'b1;
               op_rs1_q   <= cap_rs1;
               op_rs2_q   <= cap_rs2;
            end
            HOLD: begin
               if (bus.op_ready) begin
                  op_valid_q <= 1'b0;
                  state      <= accept ? READ : IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               op_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural register file answers the read
// ports, directed requests push hand-computed operands into a queue and a
// monitor pops and compares on every op_valid/op_ready handshake.
module tb_operand_fetch;
   import copperv_pkg::*;

   localparam logic [31:0] DROP = 32'hBAD0_BAD0;
   localparam logic [31:0] GARB = 32'h5A5A_A5A5;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } exp_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   exp_t exp_q[$];
   logic [31:0] regs [32];

   operand_fetch_if bus_if ();

   operand_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: 1-cycle reads, rs2 only with rs1, reads dropped
   // when a write happens in the same cycle, garbage when not reading.
   always @(posedge clk) begin
      if (bus_if.rf_rs1_en)
         bus_if.rf_rs1_dout <= bus_if.rf_rd_en ? DROP : regs[bus_if.rf_rs1];
      else
         bus_if.rf_rs1_dout <= GARB;
      if (bus_if.rf_rs2_en)
         bus_if.rf_rs2_dout <= (bus_if.rf_rd_en || !bus_if.rf_rs1_en) ? DROP : regs[bus_if.rf_rs2];
      else
         bus_if.rf_rs2_dout <= GARB;
      if (bus_if.rf_rd_en)
         regs[bus_if.rf_rd] <= bus_if.rf_rd_din;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Scoreboard monitor: compare operands on each accepted handshake.
   always @(negedge clk) begin
      if (rst && bus_if.op_valid && bus_if.op_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL op_unexpected: got op_rs1=%h op_rs2=%h, expected no output", bus_if.op_rs1, bus_if.op_rs2);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("op_rs1", bus_if.op_rs1, e.rs1);
            chk("op_rs2", bus_if.op_rs2, e.rs2);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_set(input logic v, input reg_adr_td rd, input logic [31:0] d);
      bus_if.wb_valid = v;
      bus_if.wb_rd    = rd;
      bus_if.wb_data  = d;
   endtask

   // Offer a request until accepted; returns in the READ cycle.
   task automatic issue(input logic e1, input reg_adr_td a1, input logic e2, input reg_adr_td a2,
                        input logic push, input logic [31:0] x1, input logic [31:0] x2);
      int budget;
      exp_t e;
      bus_if.dec_valid  = 1'b1;
      bus_if.dec_rs1_en = e1;
      bus_if.dec_rs2_en = e2;
      bus_if.dec_rs1    = a1;
      bus_if.dec_rs2    = a2;
      #1;
      budget = 8;
      while (!bus_if.dec_ready && budget > 0) begin
         tick();
         #1;
         budget--;
      end
      chk("accept", 32'(bus_if.dec_ready), 32'd1);
      chk("rf_rs1_en", 32'(bus_if.rf_rs1_en), 32'(e1 | e2));
      chk("rf_rs2_en", 32'(bus_if.rf_rs2_en), 32'(e2));
      chk("rf_rs1", 32'(bus_if.rf_rs1), 32'(a1));
      chk("rf_rs2", 32'(bus_if.rf_rs2), 32'(a2));
      if (push) begin
         e.rs1 = x1;
         e.rs2 = x2;
         exp_q.push_back(e);
      end
      tick();
      bus_if.dec_valid = 1'b0;
      #1;
      chk("read_op_valid", 32'(bus_if.op_valid), 32'd0);
      chk("issue_pulse", 32'(bus_if.rf_rs1_en), 32'd0);
   endtask

   // Advance from READ to HOLD and confirm op_valid at accept+2.
   task automatic expect_hold();
      tick();
      wb_set(1'b0, '0, '0);
      #1;
      chk("hold_op_valid", 32'(bus_if.op_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b0;
      bus_if.dec_valid  = 1'b0;
      bus_if.dec_rs1_en = 1'b0;
      bus_if.dec_rs2_en = 1'b0;
      bus_if.dec_rs1    = '0;
      bus_if.dec_rs2    = '0;
      bus_if.op_ready   = 1'b1;
      wb_set(1'b0, '0, '0);

      // Reset state
      tick();
      tick();
      chk("rst_op_valid", 32'(bus_if.op_valid), 32'd0);
      chk("rst_op_rs1", bus_if.op_rs1, 32'd0);
      chk("rst_op_rs2", bus_if.op_rs2, 32'd0);
      chk("rst_dec_ready", 32'(bus_if.dec_ready), 32'd1);
      rst = 1'b1;
      tick();

      // wb x5, then read it back with rs2=x0
      wb_set(1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      chk("wb_rd_en", 32'(bus_if.rf_rd_en), 32'd1);
      chk("wb_rd", 32'(bus_if.rf_rd), 32'd5);
      chk("wb_din", bus_if.rf_rd_din, 32'hDEAD_BEEF);
      chk("wb_blocks_ready", 32'(bus_if.dec_ready), 32'd0);
      tick();
      wb_set(1'b0, '0, '0);
      issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'd0);
      expect_hold();
      tick();

      // Request colliding with a writeback waits one cycle, sees new value
      wb_set(1'b1, 5'd6, 32'h6666_6666);
      bus_if.dec_valid  = 1'b1;
      bus_if.dec_rs1_en = 1'b1;
      bus_if.dec_rs2_en = 1'b1;
      bus_if.dec_rs1    = 5'd6;
      bus_if.dec_rs2    = 5'd5;
      #1;
      chk("collide_ready", 32'(bus_if.dec_ready), 32'd0);
      tick();
      wb_set(1'b0, '0, '0);
      issue(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 32'h6666_6666, 32'hDEAD_BEEF);
      expect_hold();
      tick();

      // rs2-only request with bypass from writeback in the READ cycle
      issue(1'b0, 5'd9, 1'b1, 5'd7, 1'b1, 32'd0, 32'h1234_5678);
      wb_set(1'b1, 5'd7, 32'h1234_5678);
      expect_hold();
      tick();

      // rs2-only request served from the register file
      wb_set(1'b1, 5'd3, 32'h3333_3333);
      tick();
      wb_set(1'b0, '0, '0);
      issue(1'b0, 5'd1, 1'b1, 5'd3, 1'b1, 32'd0, 32'h3333_3333);
      expect_hold();
      tick();

      // Back-pressure: operands frozen across a matching writeback
      bus_if.op_ready = 1'b0;
      issue(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      expect_hold();
      bus_if.dec_valid  = 1'b1;
      bus_if.dec_rs1_en = 1'b1;
      bus_if.dec_rs2_en = 1'b0;
      bus_if.dec_rs1    = 5'd5;
      bus_if.dec_rs2    = 5'd0;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) wb_set(1'b1, 5'd5, 32'hAAAA_AAAA);
         #1;
         chk("stall_op_valid", 32'(bus_if.op_valid), 32'd1);
         chk("stall_op_rs1", bus_if.op_rs1, 32'hDEAD_BEEF);
         chk("stall_op_rs2", bus_if.op_rs2, 32'h1234_5678);
         chk("stall_dec_ready", 32'(bus_if.dec_ready), 32'd0);
         tick();
         wb_set(1'b0, '0, '0);
      end
      bus_if.op_ready = 1'b1;
      issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 32'hAAAA_AAAA, 32'd0);
      expect_hold();
      tick();

      // x0: writes suppressed, operands zero even with x0 bypass candidate
      wb_set(1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk("x0_rd_en", 32'(bus_if.rf_rd_en), 32'd0);
      tick();
      wb_set(1'b0, '0, '0);
      issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'd0, 32'd0);
      wb_set(1'b1, 5'd0, 32'hFFFF_FFFF);
      expect_hold();
      tick();

      // Reset during READ discards the request
      issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_read_op_valid", 32'(bus_if.op_valid), 32'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_op_valid", 32'(bus_if.op_valid), 32'd0);
         chk("post_rst_ready", 32'(bus_if.dec_ready), 32'd1);
      end

      // Reset during HOLD drops op_valid without a clock edge
      bus_if.op_ready = 1'b0;
      issue(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      expect_hold();
      chk("hold_pre_rst_rs1", bus_if.op_rs1, 32'h3333_3333);
      rst = 1'b0;
      #1;
      chk("rst_hold_op_valid", 32'(bus_if.op_valid), 32'd0);
      chk("rst_hold_op_rs1", bus_if.op_rs1, 32'd0);
      tick();
      rst = 1'b1;
      bus_if.op_ready = 1'b1;
      tick();
      tick();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
